link_serdes_tx: RTL and testbench

- Transmit end of the narrow A<->B link.
- Accepts a wide payload word on a valid/ready input and serialises it into DATA_WIDTH/LINK_WIDTH narrow beats on a valid/ready link interface, least-significant slice first.
- Flags the final beat of each word with link_last. The matching receiver reassembles the word.
- Sits between a module's data_to_B-style output and the inter-module wire, reducing wire count for wide channels.

---
 rtl/link_serdes_tx.sv | 87 ++++++++
 tb/tb_link_serdes_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/link_serdes_tx.sv
// Transmit end of the narrow A<->B link.
// Serialises wide payload words into LSB-first link beats.
module link_serdes_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int LINK_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  link_valid,
  input  logic                  link_ready,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int NBEATS = DATA_WIDTH / LINK_WIDTH;
  localparam int BW = (NBEATS > 2) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;

  logic sending;
  logic accept;
  logic fire;
  logic last;

  assign sending = (state_q == SEND);
  assign last    = sending && (cnt_q == LAST_BEAT);
  assign fire    = sending && link_ready;

  // Ready in SEND only on the last beat so the next word follows without a bubble
  assign in_ready = rst_n && (!sending || (link_ready && last));
  assign accept   = in_valid && in_ready;

  assign link_valid = sending;
  assign link_data  = shreg_q[LINK_WIDTH-1:0];
  assign link_last  = last;
  assign busy       = sending;
  assign words_sent = sent_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sent_d  = sent_q;
    if (accept) begin
      state_d = SEND;
      cnt_d   = '0;
      shreg_d = in_data;
    end else if (fire) begin
      cnt_d   = cnt_q + 1'b1;
      shreg_d = shreg_q >> LINK_WIDTH;
      if (last) begin
        state_d = IDLE;
      end
    end
    if (fire && last && !(&sent_q)) begin
      sent_d = sent_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sent_q  <= sent_d;
    end
  end

endmodule

// File: tb/tb_link_serdes_tx.sv
// Directed bench for link_serdes_tx: default, saturating-counter
// and 16-bit instances sharing one clock and reset.
module tb_link_serdes_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Main instance, 32/8/16
  logic        a_iv, a_ir, a_lv, a_lr, a_ll, a_busy;
  logic [31:0] a_id;
  logic [7:0]  a_ld;
  logic [15:0] a_ws;

  link_serdes_tx #(.DATA_WIDTH(32), .LINK_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .link_valid(a_lv), .link_ready(a_lr), .link_data(a_ld),
    .link_last(a_ll), .busy(a_busy), .words_sent(a_ws)
  );

  // Saturation instance, CNT_WIDTH=4
  logic        s_iv, s_ir, s_lv, s_lr, s_ll, s_busy;
  logic [31:0] s_id;
  logic [7:0]  s_ld;
  logic [3:0]  s_ws;

  link_serdes_tx #(.DATA_WIDTH(32), .LINK_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
    .link_valid(s_lv), .link_ready(s_lr), .link_data(s_ld),
    .link_last(s_ll), .busy(s_busy), .words_sent(s_ws)
  );

  // Narrow instance, 16/8
  logic        n_iv, n_ir, n_lv, n_lr, n_ll, n_busy;
  logic [15:0] n_id;
  logic [7:0]  n_ld;
  logic [15:0] n_ws;

  link_serdes_tx #(.DATA_WIDTH(16), .LINK_WIDTH(8), .CNT_WIDTH(16)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_iv), .in_ready(n_ir), .in_data(n_id),
    .link_valid(n_lv), .link_ready(n_lr), .link_data(n_ld),
    .link_last(n_ll), .busy(n_busy), .words_sent(n_ws)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b1 [4];
  logic [7:0] b2 [8];

  initial begin
    rst_n = 1'b0;
    a_iv = 0; a_lr = 1; a_id = '0;
    s_iv = 0; s_lr = 1; s_id = '0;
    n_iv = 0; n_lr = 1; n_id = '0;
    step();
    step();
    #1;

    // Reset state
    check("rst_in_ready", a_ir, 0);
    check("rst_link_valid", a_lv, 0);
    check("rst_link_last", a_ll, 0);
    check("rst_link_data", a_ld, 0);
    check("rst_busy", a_busy, 0);
    check("rst_words", a_ws, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", a_ir, 1);

    // Single word
    b1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    a_id = 32'hA1B2C3D4; a_iv = 1;
    step();
    a_iv = 0; a_id = 32'hFFFFFFFF;
    #1;
    check("w1_in_ready_mid", a_ir, 0);
    for (int i = 0; i < 4; i++) begin
      check("w1_valid", a_lv, 1);
      check("w1_data", a_ld, b1[i]);
      check("w1_last", a_ll, (i == 3) ? 1 : 0);
      step();
    end
    check("w1_valid_after", a_lv, 0);
    check("w1_busy_after", a_busy, 0);
    check("w1_words", a_ws, 1);

    // Back-to-back words
    b2 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    a_id = 32'h11223344; a_iv = 1;
    step();
    a_id = 32'h55667788;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        a_iv = 0;
        a_id = 32'h0BADF00D;
        #1;
      end
      check("b2b_valid", a_lv, 1);
      check("b2b_data", a_ld, b2[i]);
      check("b2b_last", a_ll, (i == 3 || i == 7) ? 1 : 0);
      check("b2b_in_ready", a_ir, (i == 3 || i == 7) ? 1 : 0);
      step();
    end
    check("b2b_valid_after", a_lv, 0);
    check("b2b_words", a_ws, 3);

    // Backpressure on the second beat
    a_id = 32'hDEADBEEF; a_iv = 1;
    step();
    a_iv = 0;
    #1;
    check("bp_b0", a_ld, 8'hEF);
    step();
    check("bp_b1", a_ld, 8'hBE);
    a_lr = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_stall_valid", a_lv, 1);
      check("bp_stall_data", a_ld, 8'hBE);
      check("bp_stall_last", a_ll, 0);
      check("bp_stall_in_ready", a_ir, 0);
      step();
    end
    a_lr = 1;
    #1;
    check("bp_b1_release", a_ld, 8'hBE);
    step();
    check("bp_b2", a_ld, 8'hAD);
    check("bp_b2_last", a_ll, 0);
    step();
    check("bp_b3", a_ld, 8'hDE);
    check("bp_b3_last", a_ll, 1);
    step();
    check("bp_valid_after", a_lv, 0);
    check("bp_words", a_ws, 4);

    // Reset mid-word
    a_id = 32'hA1B2C3D4; a_iv = 1;
    step();
    a_iv = 0;
    #1;
    check("rm_b0", a_ld, 8'hD4);
    step();
    check("rm_b1", a_ld, 8'hC3);
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    check("rm_valid", a_lv, 0);
    check("rm_busy", a_busy, 0);
    check("rm_words", a_ws, 0);
    check("rm_last", a_ll, 0);

    // Accept attempt during reset is blocked
    rst_n = 0; a_iv = 1; a_id = 32'hCAFEF00D;
    #1;
    check("rs_in_ready", a_ir, 0);
    step();
    rst_n = 1; a_iv = 0;
    #1;
    check("rs_busy", a_busy, 0);
    check("rs_valid", a_lv, 0);

    b1 = '{8'h04, 8'h03, 8'h02, 8'h01};
    a_id = 32'h01020304; a_iv = 1;
    step();
    a_iv = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("pr_data", a_ld, b1[i]);
      check("pr_last", a_ll, (i == 3) ? 1 : 0);
      step();
    end
    check("pr_words", a_ws, 1);

    // Counter saturation with CNT_WIDTH=4
    s_id = 32'h12345678;
    for (int w = 1; w <= 17; w++) begin
      s_iv = 1;
      step();
      s_iv = 0;
      for (int b = 0; b < 4; b++) step();
      check("sat_words", s_ws, (w > 15) ? 15 : w);
    end

    // 16-bit payload over 8-bit link
    n_id = 16'hBEEF; n_iv = 1;
    step();
    n_iv = 0;
    #1;
    check("n_b0", n_ld, 8'hEF);
    check("n_b0_last", n_ll, 0);
    step();
    check("n_b1", n_ld, 8'hBE);
    check("n_b1_last", n_ll, 1);
    step();
    check("n_valid_after", n_lv, 0);
    check("n_words", n_ws, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
